rx_word_packer: RTL and testbench
=================================

# rx_word_packer

Byte-to-word assembler directly downstream of the flash-image byte source. Consumes the `rx_data`/`rx_valid` byte stream on `clk_rx` and packs four bytes little-endian into 32-bit words. Buffers words in a small FIFO and presents them with a valid/ready write handshake, carrying an incrementing word address, to the flash/SRAM programming port. Stops after a programmed word count and reports done and overflow status.

## Interface
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, ≥2.
- `ADDR_W`, 14: width of the word address.
- `BASE_ADDR`, 0: address of the first word written.
- `NUM_WORDS`, 5676: words to accept before `done`; 1..2^ADDR_W.

- `clk_rx` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous active-low reset, sampled on `clk_rx`.
- `rx_data` in 8: byte from upstream.
- `rx_valid` in 1: byte strobe, sampled high on a `clk_rx` edge = one byte.
- `flush` in 1: one-cycle pulse; emits a pending partial word, padded with zeros.
- `wr_valid` out 1: FIFO head valid.
- `wr_ready` in 1: downstream accepts the head word.
- `wr_addr` out ADDR_W: word address of the head.
- `wr_data` out 32: head word, byte 0 in bits [7:0].
- `wr_be` out 4: byte enables of the head; 4'hF for full words.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; a completed word was dropped.
- `done` out 1: `NUM_WORDS` handshakes have completed.

## Operation
- **FSM states:** RUN and DONE.
  - Reset enters RUN.
  - RUN moves to DONE on the handshake that completes word `NUM_WORDS`.
  - DONE is left only by reset.
- **Byte capture (RUN):** each `rx_valid` high cycle writes `rx_data` into lane `lane_cnt` (2 bits) of the assembly register, then increments `lane_cnt` mod 4.
- **Full word:** when `lane_cnt`=3 and `rx_valid`=1, push {`rx_data`, asm[23:0]} with be=4'hF; `lane_cnt` returns to 0.
- **Flush:** `flush`=1 with `lane_cnt`≠0 pushes the partial word.
  - Unfilled lanes are 0; `wr_be` has one bit set per filled lane.
  - `lane_cnt` is cleared.
  - If `rx_valid` is high in the same cycle, that byte is merged first. If the merge fills lane 3, it is a normal full push and no extra word is produced.
  - `flush` with `lane_cnt`=0 and no byte is a no-op.
- **Push rule:** a push succeeds if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the word is dropped, `overflow` is set, and `lane_cnt` still resets.
- **Pop:** `wr_valid && wr_ready`. Each pop increments the address counter, which starts at `BASE_ADDR` and wraps at 2^ADDR_W.
  - `wr_addr` is the counter value, so no address is stored per entry.
- **Word count:** counts pops, not pushes.
- **DONE state:** `rx_valid` and `flush` are ignored. Words still in the FIFO keep draining with valid addresses. `done` stays high.
- **Overflow:** sticky until reset.

## Timing
- **Reset values:** `wr_valid`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0, `wr_be`=0, `fifo_level`=0, `overflow`=0, `done`=0, `lane_cnt`=0.
- **Latency:** the 4th byte is sampled at edge N and pushed at edge N. `wr_valid`/`wr_data` are visible after edge N (FIFO head is show-ahead, registered). Byte-to-output latency is 1 cycle.
- **Throughput:** sustained `rx_valid` every cycle gives 1 word per 4 cycles. A FIFO of ≥2 entries with `wr_ready` held high never overflows.
- **Handshake:** `wr_data`/`wr_addr`/`wr_be` are stable while `wr_valid`=1 and `wr_ready`=0. `wr_valid` does not depend combinationally on `wr_ready`.
- **`done`:** rises in the cycle after the final pop edge.
- **`overflow`:** rises in the cycle after the drop edge.
- **`fifo_level`:**
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- **Reset mid-word or mid-drain:** discards all buffered bytes and words. No `wr_valid` in the cycle after reset deasserts.

## Structure
- **Shared package `flash_pkg`:**
  - `WORD_W`=32, `BYTES_PER_WORD`=4, `LANE_W`=2.
  - FSM state typedef `{RUN, DONE}`.
  - FIFO entry typedef {data[31:0], be[3:0]}.
- **Sub-module `sync_fifo`:** parameterised width and depth, synchronous reset, show-ahead, ports push/pop/full/empty/level. The packer FSM, lane logic and counters stay in the top level.

## Test plan
- **Basic pack:** bytes 01,02,03,04,05,06,07,08 with `wr_ready`=1 → words 0x04030201 @`BASE_ADDR`, then 0x08070605 @`BASE_ADDR`+1, `wr_be`=F, each 1 cycle after its 4th byte.
- **Flush:** bytes AA,BB then a `flush` pulse → word 0x0000BBAA, `wr_be`=4'b0011, `lane_cnt` back to 0; a second `flush` produces nothing.
- **Backpressure and overflow:** `wr_ready`=0, FIFO_DEPTH=4, 20 bytes 00..13 → 4 words held with stable head 0x03020100. The 5th word is dropped, `overflow`=1, `fifo_level`=4. Releasing `wr_ready` drains 4 words at consecutive addresses.
- **Done:** NUM_WORDS=3, 16 bytes streamed → exactly 3 handshakes; `done`=1 the cycle after the 3rd; the 4th word is never presented; later `rx_valid` is ignored.
- **Simultaneous push/pop at full:** FIFO full with `wr_ready` pulsed in the same cycle as a 4th byte → push accepted, `fifo_level` stays 4, no overflow.
- **Reset mid-word:** 2 bytes, then `rst_n`=0 for 1 cycle, then bytes 11,22,33,44 → first word 0x44332211 @`BASE_ADDR`.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared definitions for the flash-image byte packer.
// Holds the word geometry, the packer FSM state type, the FIFO entry layout
// and a helper that builds a zero-padded partial word from the assembly bytes.
package flash_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    // state | meaning
    // RUN   | accepting bytes, packing and pushing words
    // DONE  | word count reached; input ignored, FIFO keeps draining
    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0]         data;
        logic [BYTES_PER_WORD-1:0] be;
    } fifo_entry_t;

    // Lanes at or above n_filled are forced to zero: the assembly register
    // still holds bytes from earlier words in those lanes.
    function automatic fifo_entry_t pack_partial(input logic [23:0]       asm_bytes,
                                                 input logic [LANE_W-1:0] n_filled);
        fifo_entry_t e;
        e = '0;
        case (n_filled)
            2'd1:    e.be = 4'b0001;
            2'd2:    e.be = 4'b0011;
            2'd3:    e.be = 4'b0111;
            default: e.be = 4'b0000;
        endcase
        for (int i = 0; i < 3; i++) begin
            if (e.be[i]) e.data[i*8 +: 8] = asm_bytes[i*8 +: 8];
        end
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with registered storage.
// Ports: i_clk/i_rst_n (sync active-low reset), i_push/i_din write side,
// i_pop read side, o_dout head entry (zero while empty), o_full, o_empty,
// o_level occupancy. A push while full is accepted only together with a pop.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   LVL_ONE = 1;
    localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == LVL_MAX);
    assign o_level   = r_level;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // When full, a simultaneous push writes the slot being popped this edge.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/rx_word_packer.sv
// Packs a byte stream little-endian into 32-bit words, buffers them in a
// show-ahead FIFO and presents them on a valid/ready write port with an
// incrementing word address. Stops accepting bytes after NUM_WORDS pops.
// Ports: clk_rx, rst_n (sync active-low); rx_data/rx_valid byte input;
// flush emits a pending partial word; wr_valid/wr_ready/wr_addr/wr_data/wr_be
// write port; fifo_level occupancy; overflow (sticky drop); done.
module rx_word_packer
    import flash_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 14,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_WORDS  = 5676
) (
    input  logic                          clk_rx,
    input  logic                          rst_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          flush,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [WORD_W-1:0]             wr_data,
    output logic [BYTES_PER_WORD-1:0]     wr_be,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LP_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]  LP_LAST  = CNT_W'(NUM_WORDS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LANE_W-1:0] r_lane;
    logic [LANE_W-1:0] w_lane_nxt;
    logic [23:0]       r_asm;
    logic [23:0]       w_asm_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_pop_cnt;
    logic              r_overflow;
    fifo_entry_t       w_entry;
    fifo_entry_t       w_head;
    logic              w_push;
    logic              w_push_ok;
    logic              w_drop;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    assign w_pop     = !w_empty && wr_ready;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && !w_push_ok;

    always_ff @(posedge clk_rx) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_pop && r_pop_cnt == LP_LAST) w_state_nxt = DONE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = RUN;
        endcase
    end

    // Lane capture and word build. A byte arriving with flush is merged
    // before the partial word is formed; filling lane 3 is always a full push.
    always_comb begin
        w_push     = 1'b0;
        w_entry    = '0;
        w_lane_nxt = r_lane;
        w_asm_nxt  = r_asm;
        if (r_state == RUN) begin
            if (rx_valid) begin
                if (r_lane == 2'd3) begin
                    w_push       = 1'b1;
                    w_entry.data = {rx_data, r_asm};
                    w_entry.be   = 4'hF;
                    w_lane_nxt   = 2'd0;
                end else begin
                    case (r_lane)
                        2'd0:    w_asm_nxt[7:0]   = rx_data;
                        2'd1:    w_asm_nxt[15:8]  = rx_data;
                        default: w_asm_nxt[23:16] = rx_data;
                    endcase
                    w_lane_nxt = r_lane + 2'd1;
                    if (flush) begin
                        w_push     = 1'b1;
                        w_entry    = pack_partial(w_asm_nxt, r_lane + 2'd1);
                        w_lane_nxt = 2'd0;
                    end
                end
            end else if (flush && r_lane != 2'd0) begin
                w_push     = 1'b1;
                w_entry    = pack_partial(r_asm, r_lane);
                w_lane_nxt = 2'd0;
            end
        end
    end

    always_ff @(posedge clk_rx) begin
        if (!rst_n) begin
            r_lane     <= '0;
            r_asm      <= '0;
            r_addr     <= LP_BASE;
            r_pop_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_lane <= w_lane_nxt;
            r_asm  <= w_asm_nxt;
            if (w_pop) r_addr <= r_addr + ADDR_ONE;
            if (w_pop && r_state == RUN) r_pop_cnt <= r_pop_cnt + CNT_ONE;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_rx),
        .i_rst_n (rst_n),
        .i_push  (w_push_ok),
        .i_din   (w_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign wr_valid = !w_empty;
    assign wr_data  = w_head.data;
    assign wr_be    = w_head.be;
    assign wr_addr  = r_addr;
    assign overflow = r_overflow;
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_rx_word_packer.sv
// Self-checking bench for rx_word_packer: a queue-based reference model is
// compared against the DUT every cycle, plus literal expectations for the
// directed scenarios and a randomized soak.
module tb_rx_word_packer;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 14;
    localparam int BASE_ADDR  = 16368;   // 14'h3FF0, wraps after 16 words
    localparam int NUM_WORDS  = 100;
    localparam logic [13:0] P_BASE = 14'h3FF0;

    logic        clk_rx = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        flush = 1'b0;
    logic        wr_ready = 1'b0;
    logic        wr_valid;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        done;

    always #5 clk_rx = ~clk_rx;

    rx_word_packer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR),
        .NUM_WORDS  (NUM_WORDS)
    ) dut (
        .clk_rx     (clk_rx),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .done       (done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending bytes, queue of buffered words, counters.
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
    } word_t;

    word_t       m_q[$];
    logic [7:0]  m_bytes[$];
    logic [13:0] m_addr = P_BASE;
    int          m_cnt = 0;
    bit          m_done = 1'b0;
    bit          m_ovf = 1'b0;

    always @(posedge clk_rx) begin
        if (!rst_n) begin
            m_q.delete();
            m_bytes.delete();
            m_addr = P_BASE;
            m_cnt  = 0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
        end else begin : model_step
            bit    pop;
            bit    push;
            word_t w;
            pop  = (m_q.size() > 0) && wr_ready;
            push = 1'b0;
            w    = '0;
            if (!m_done) begin
                if (rx_valid) m_bytes.push_back(rx_data);
                if (m_bytes.size() == 4 || (flush && m_bytes.size() > 0)) begin
                    foreach (m_bytes[i]) begin
                        w.data[8*i +: 8] = m_bytes[i];
                        w.be[i] = 1'b1;
                    end
                    m_bytes.delete();
                    push = 1'b1;
                end
            end
            if (pop) begin
                void'(m_q.pop_front());
                m_addr++;
                m_cnt++;
                if (m_cnt == NUM_WORDS) m_done = 1'b1;
            end
            if (push) begin
                if (m_q.size() < FIFO_DEPTH) m_q.push_back(w);
                else m_ovf = 1'b1;
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk_rx) begin
        if (chk_en) begin
            check("wr_valid", wr_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                check("wr_data", wr_data, m_q[0].data);
                check("wr_be", wr_be, m_q[0].be);
            end
            check("wr_addr", wr_addr, m_addr);
            check("fifo_level", fifo_level, m_q.size());
            check("overflow", overflow, m_ovf);
            check("done", done, m_done);
        end
    end

    int hs_cnt = 0;
    always @(negedge clk_rx) begin
        if (!rst_n) hs_cnt = 0;
        else if (wr_valid && wr_ready) hs_cnt++;
    end

    task automatic tick();
        @(posedge clk_rx);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rx_valid = 1'b0; flush = 1'b0; wr_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;

        // reset values
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_data", wr_data, 32'h0);
        check("rst_wr_be", wr_be, 4'h0);
        check("rst_wr_addr", wr_addr, 14'h3FF0);
        check("rst_level", fifo_level, 3'd0);

        // basic pack
        wr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(8'(i));
        check("basic_w0_valid", wr_valid, 1'b1);
        check("basic_w0_data", wr_data, 32'h04030201);
        check("basic_w0_addr", wr_addr, 14'h3FF0);
        check("basic_w0_be", wr_be, 4'hF);
        send(8'h05);
        check("basic_popped", wr_valid, 1'b0);
        for (int i = 6; i <= 8; i++) send(8'(i));
        check("basic_w1_data", wr_data, 32'h08070605);
        check("basic_w1_addr", wr_addr, 14'h3FF1);
        tick();
        wr_ready = 1'b0;

        // flush
        send(8'hAA);
        send(8'hBB);
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_data", wr_data, 32'h0000BBAA);
        check("flush_be", wr_be, 4'b0011);
        check("flush_level", fifo_level, 3'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_noop_level", fifo_level, 3'd1);
        for (int i = 0; i < 4; i++) send(8'hC1 + 8'(i));
        check("flush_lane_reset_level", fifo_level, 3'd2);
        // byte merged with flush
        send(8'hD1);
        rx_valid = 1'b1; rx_data = 8'hD2; flush = 1'b1; tick();
        rx_valid = 1'b0; flush = 1'b0;
        check("merge_level", fifo_level, 3'd3);
        wr_ready = 1'b1;
        repeat (4) tick();
        wr_ready = 1'b0;

        // backpressure and overflow
        do_reset();
        for (int i = 0; i < 20; i++) send(8'(i));
        check("bp_level", fifo_level, 3'd4);
        check("bp_overflow", overflow, 1'b1);
        check("bp_head", wr_data, 32'h03020100);
        check("bp_addr", wr_addr, 14'h3FF0);
        wr_ready = 1'b1;
        tick();
        check("bp_drain1_data", wr_data, 32'h07060504);
        check("bp_drain1_addr", wr_addr, 14'h3FF1);
        repeat (3) tick();
        check("bp_drained", wr_valid, 1'b0);
        check("bp_final_addr", wr_addr, 14'h3FF4);
        wr_ready = 1'b0;

        // simultaneous push and pop at full
        do_reset();
        for (int i = 0; i < 19; i++) send(8'(i));
        check("sim_full", fifo_level, 3'd4);
        rx_valid = 1'b1; rx_data = 8'd19; wr_ready = 1'b1;
        tick();
        rx_valid = 1'b0; wr_ready = 1'b0;
        check("sim_level", fifo_level, 3'd4);
        check("sim_overflow", overflow, 1'b0);
        check("sim_head", wr_data, 32'h07060504);
        check("sim_addr", wr_addr, 14'h3FF1);

        // reset mid-word
        do_reset();
        send(8'hE1);
        send(8'hE2);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        send(8'h11);
        check("rmw_no_valid", wr_valid, 1'b0);
        send(8'h22); send(8'h33); send(8'h44);
        check("rmw_data", wr_data, 32'h44332211);
        check("rmw_addr", wr_addr, 14'h3FF0);

        // done
        do_reset();
        wr_ready = 1'b1;
        for (int w = 0; w < NUM_WORDS + 2; w++)
            for (int b = 0; b < 4; b++) send(8'(w * 4 + b));
        repeat (3) tick();
        check("done_flag", done, 1'b1);
        check("done_handshakes", hs_cnt, NUM_WORDS);
        check("done_addr", wr_addr, 14'h0054);
        for (int i = 0; i < 8; i++) send(8'hF0 + 8'(i));
        tick();
        check("done_ignore_level", fifo_level, 3'd0);
        check("done_ignore_hs", hs_cnt, NUM_WORDS);
        wr_ready = 1'b0;

        // randomized soak
        for (int run = 0; run < 3; run++) begin
            do_reset();
            for (int cyc = 0; cyc < 1500; cyc++) begin
                rx_valid = ($urandom % 10) < 7;
                rx_data  = 8'($urandom);
                flush    = ($urandom % 16) == 0;
                case (run)
                    0:       wr_ready = ($urandom % 10) < 9;
                    1:       wr_ready = ($urandom % 2) == 0;
                    default: wr_ready = ($urandom % 5) == 0;
                endcase
                rst_n = ($urandom % 500) != 0;
                tick();
            end
            rx_valid = 1'b0; flush = 1'b0; rst_n = 1'b1;
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
